// File: rtl/execute_muldiv.sv
// M-extension mul/div: N+1 edges accept-to-out_valid (2 for trivial cases under MULDIV_EARLY_OUT_EN); shift-add multiplier, restoring divider.
// in_ready only in IDLE; result holds in DONE until out_ready; flush kills any in-flight op.
module execute_muldiv #(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] N_MUL  = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] N_MULW = CW'(32 / MUL_BITS - 1);
    localparam logic [CW-1:0] N_DIV  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] N_DIVW = CW'(31);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] hi_q, lo_q, mc_q, dvd_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             word_q, neg_q, aneg_q, div0_q, ovf_q, mzero_q;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r       = {WIDTH{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] zext32(input logic [31:0] v);
        logic [WIDTH-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic a_signed, b_signed;
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
    end

    // W forms exist only for MUL and the divide group, and only on a 64-bit datapath
    logic             word_op, accept, a_neg, b_neg, div0_in, ovf_in, mzero_in, early_in;
    logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_val, init_lo, init_mc;

    assign word_op  = word && (WIDTH == 64) && (op[2] || (op[1:0] == 2'b00));
    assign a_ext    = word_op ? (a_signed ? sext32(a[31:0]) : zext32(a[31:0])) : a;
    assign b_ext    = word_op ? (b_signed ? sext32(b[31:0]) : zext32(b[31:0])) : b;
    assign a_neg    = a_signed && a_ext[WIDTH-1];
    assign b_neg    = b_signed && b_ext[WIDTH-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    assign min_val  = word_op ? sext32(32'h8000_0000) : {1'b1, {(WIDTH-1){1'b0}}};
    assign div0_in  = (b_ext == '0);
    assign ovf_in   = a_signed && b_signed && (a_ext == min_val) && (b_ext == '1);
    assign mzero_in = (a_ext == '0) || (b_ext == '0);
    // Divider consumes dividend MSB-first, so word dividends are pre-aligned to the top
    assign init_lo  = op[2] ? (word_op ? (a_mag << (WIDTH - 32)) : a_mag) : b_mag;
    assign init_mc  = op[2] ? b_mag : a_mag;
    assign accept   = in_valid && in_ready && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_in = op[2] ? (div0_in || ovf_in) : mzero_in;
`else
    assign early_in = 1'b0;
`endif

    // The accept edge performs the first iteration on the incoming operands
    logic                      step_div, ge;
    logic [WIDTH-1:0]          src_hi, src_lo, src_mc, nxt_hi, nxt_lo, dsub;
    logic [WIDTH+MUL_BITS-1:0] sum;
    logic [WIDTH:0]            rem_sh;

    assign src_hi   = (state == S_IDLE) ? '0 : hi_q;
    assign src_lo   = (state == S_IDLE) ? init_lo : lo_q;
    assign src_mc   = (state == S_IDLE) ? init_mc : mc_q;
    assign step_div = (state == S_IDLE) ? op[2] : op_q[2];

    assign sum    = {{MUL_BITS{1'b0}}, src_hi}
                  + ({{MUL_BITS{1'b0}}, src_mc} * {{WIDTH{1'b0}}, src_lo[MUL_BITS-1:0]});
    assign rem_sh = {src_hi, src_lo[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, src_mc});
    assign dsub   = rem_sh[WIDTH-1:0] - src_mc;
    assign nxt_hi = step_div ? (ge ? dsub : rem_sh[WIDTH-1:0]) : sum[WIDTH+MUL_BITS-1:MUL_BITS];
    assign nxt_lo = step_div ? {src_lo[WIDTH-2:0], ge}
                             : {sum[MUL_BITS-1:0], src_lo[WIDTH-1:MUL_BITS]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid) state_n = early_in ? S_FIX : (op[2] ? S_DIV : S_MUL);
            S_MUL, S_DIV: if (cnt_q == CW'(1)) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    // Sign correction and hi/lo/quotient/remainder selection
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [31:0]        m32, m32s;
    logic [WIDTH-1:0]   quo, rem, fix_res;
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        m32    = lo_q[WIDTH-1:WIDTH-32];
        m32s   = neg_q ? -m32 : m32;
        quo    = neg_q ? -lo_q : lo_q;
        rem    = aneg_q ? -hi_q : hi_q;
        if (div0_q) begin
            quo = '1;
            rem = dvd_q;
        end else if (ovf_q) begin
            quo = dvd_q;
            rem = '0;
        end
        fix_res = '0;
        case (op_q)
            3'd0:             fix_res = word_q ? sext32(m32s) : prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       fix_res = word_q ? sext32(quo[31:0]) : quo;
            default:          fix_res = word_q ? sext32(rem[31:0]) : rem;
        endcase
        if (mzero_q && !op_q[2]) fix_res = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mzero_q <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                hi_q    <= nxt_hi;
                lo_q    <= nxt_lo;
                mc_q    <= init_mc;
                dvd_q   <= a_ext;
                op_q    <= op;
                word_q  <= word_op;
                neg_q   <= a_neg ^ b_neg;
                aneg_q  <= a_neg;
                div0_q  <= div0_in;
                ovf_q   <= ovf_in;
                mzero_q <= mzero_in;
                cnt_q   <= op[2] ? (word_op ? N_DIVW : N_DIV) : (word_op ? N_MULW : N_MUL);
            end else if (state == S_MUL || state == S_DIV) begin
                hi_q  <= nxt_hi;
                lo_q  <= nxt_lo;
                cnt_q <= cnt_q - CW'(1);
            end
            if (state == S_FIX && !flush) result <= fix_res;
        end
    end

endmodule
